instr_fetch_ctrl: RTL



---
 rtl/fetch_pkg.sv | 18 +
 rtl/instr_fetch_ctrl_if.sv | 41 ++++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch sequencer.
package fetch_pkg;

    localparam logic [31:0] RESET_PC          = 32'h0000_0000;
    localparam int unsigned MEM_BYTES_DEFAULT = 1024;
    localparam int unsigned DEPTH_DEFAULT     = 2;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Memory, IF/ID handshake, redirect and fault signals of the fetch sequencer.
interface instr_fetch_ctrl_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  branch_taken,
        input  branch_addr,
        output fault,
        output fault_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output branch_taken,
        output branch_addr,
        input  fault,
        input  fault_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of fetched {instr, pc4} entries with synchronous clear.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    output fetch_entry_t dout,
    output logic         full_c,
    output logic         empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;

    // Clear wins over push/pop so a redirect never leaves a stale entry behind.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (clr) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q[AW-1:0]] = din;
                wr_d                = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

    assign dout    = mem_q[rd_q[AW-1:0]];
    assign full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_c = (wr_q == rd_q);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, fills the prefetch queue, applies redirects and halts out of range.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int unsigned DEPTH     = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_ctrl_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic         fifo_clr_c, fifo_push_c, fifo_pop_c;
    logic         fifo_full_c, fifo_empty_c;
    fetch_entry_t push_entry_c, head_c;

    // 33-bit compare so addresses close to 2^32 cannot wrap into range.
    function automatic logic word_in_range(input logic [31:0] addr);
        return ({1'b0, addr} + 33'd3) < 33'(MEM_BYTES);
    endfunction

    assign fifo_pop_c = !fifo_empty_c && bus.out_ready && !bus.branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_pc_d   = fault_pc_q;
        fifo_clr_c   = 1'b0;
        fifo_push_c  = 1'b0;
        push_entry_c = '{instr: bus.imem_rdata, pc4: pc_q + 32'd4};
        if (bus.branch_taken) begin
            fifo_clr_c = 1'b1;
            if ((bus.branch_addr[1:0] == 2'b00) && word_in_range(bus.branch_addr)) begin
                state_d = RUN;
                pc_d    = bus.branch_addr;
            end else begin
                state_d    = FAULT;
                fault_pc_d = bus.branch_addr;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (!word_in_range(pc_q)) begin
                        state_d    = FAULT;
                        fault_pc_d = pc_q;
                    end else if (!fifo_full_c || fifo_pop_c) begin
                        fifo_push_c = 1'b1;
                        pc_d        = pc_q + 32'd4;
                    end
                end
                FAULT: begin
                    pc_d = pc_q;
                end
                default: begin
                    state_d = FAULT;
                end
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (fifo_clr_c),
        .push    (fifo_push_c),
        .din     (push_entry_c),
        .pop     (fifo_pop_c),
        .dout    (head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    assign bus.imem_addr = pc_q & 32'hFFFF_FFFC;
    assign bus.out_valid = !fifo_empty_c;
    assign bus.out_instr = head_c.instr;
    assign bus.out_pc    = head_c.pc4;
    assign bus.fault     = (state_q == FAULT);
    assign bus.fault_pc  = fault_pc_q;

endmodule
